// File: rtl/cic_ctrl_if.sv
// Downstream sample stream of the CIC acquisition controller: data word plus valid/ready handshake.
interface cic_ctrl_if #(
    parameter int unsigned O_WIDTH = 19
);
    logic [O_WIDTH-1:0] o_data;
    logic               o_valid;
    logic               i_ready;

    modport master (output o_data, output o_valid, input i_ready);
    modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/cic_ctrl.sv
// Acquisition controller for one CIC decimator: flush, discard settling samples,
// capture N decimated samples (or run continuously) into a valid/ready stream.
module cic_ctrl #(
    parameter int unsigned O_WIDTH        = 19,
    parameter int unsigned SETTLE_SAMPLES = 5,
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter int unsigned CNT_BITS       = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [CNT_BITS-1:0] i_num_samples,
    input  logic [O_WIDTH-1:0]  i_cic_data,
    input  logic                i_cic_clk,
    output logic                o_cic_en,
    output logic                o_cic_rst,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_overrun,
    cic_ctrl_if.master          stream
);
    localparam logic [CNT_BITS-1:0] FLUSH_LAST  =
        CNT_BITS'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
    localparam logic [CNT_BITS-1:0] SETTLE_LAST =
        CNT_BITS'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, FLUSH, SETTLE, RUN, DRAIN} state_e;

    state_e              state_q, state_d;
    logic                cic_clk_q;
    logic                cic_en_q, cic_en_d;
    logic                cic_rst_q, cic_rst_d;
    logic                busy_q;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                valid_q, valid_d;
    logic [O_WIDTH-1:0]  data_q, data_d;
    logic [CNT_BITS-1:0] num_q, num_d;
    logic [CNT_BITS-1:0] flush_q, flush_d;
    logic [CNT_BITS-1:0] settle_q, settle_d;
    logic [CNT_BITS-1:0] sample_q, sample_d;
    logic                stb;
    logic                xfer;

    assign stb  = i_cic_clk & ~cic_clk_q;
    assign xfer = valid_q & stream.i_ready;

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cic_clk_q <= 1'b0;
            cic_en_q  <= 1'b0;
            cic_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            num_q     <= '0;
            flush_q   <= '0;
            settle_q  <= '0;
            sample_q  <= '0;
        end else begin
            state_q   <= state_d;
            cic_clk_q <= i_cic_clk;
            cic_en_q  <= cic_en_d;
            cic_rst_q <= cic_rst_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= done_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            num_q     <= num_d;
            flush_q   <= flush_d;
            settle_q  <= settle_d;
            sample_q  <= sample_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cic_en_d  = cic_en_q;
        cic_rst_d = 1'b0;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        valid_d   = valid_q & ~stream.i_ready;
        data_d    = data_q;
        num_d     = num_q;
        flush_d   = flush_q;
        settle_d  = settle_q;
        sample_d  = sample_q;

        case (state_q)
            IDLE: begin
                cic_en_d = 1'b0;
                if (i_start) begin
                    state_d   = FLUSH;
                    cic_rst_d = 1'b1;
                    num_d     = i_num_samples;
                    overrun_d = 1'b0;
                    valid_d   = 1'b0;
                    flush_d   = '0;
                    settle_d  = '0;
                    sample_d  = '0;
                end
            end
            FLUSH: begin
                cic_en_d  = 1'b0;
                cic_rst_d = 1'b1;
                flush_d   = flush_q + CNT_BITS'(1);
                if (flush_q == FLUSH_LAST) begin
                    cic_rst_d = 1'b0;
                    cic_en_d  = 1'b1;
                    state_d   = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
                end
            end
            SETTLE: begin
                cic_en_d = 1'b1;
                if (stb) begin
                    settle_d = settle_q + CNT_BITS'(1);
                    if (settle_q == SETTLE_LAST) state_d = RUN;
                end
            end
            RUN: begin
                cic_en_d = 1'b1;
                if (stb) begin
                    sample_d = sample_q + CNT_BITS'(1);
                    if (!valid_q || stream.i_ready) begin
                        data_d  = i_cic_data;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    // Continuous mode (N=0) never matches; the counter just wraps
                    if ((num_q != '0) && (sample_d == num_q)) begin
                        state_d  = DRAIN;
                        cic_en_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                cic_en_d = 1'b0;
                if (!valid_q || xfer) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                cic_en_d = 1'b0;
            end
        endcase

        // Abort overrides everything, including a coincident start
        if ((state_q != IDLE) && i_stop) begin
            state_d   = IDLE;
            cic_en_d  = 1'b0;
            cic_rst_d = 1'b0;
            valid_d   = 1'b0;
            done_d    = 1'b0;
        end
    end

    assign o_cic_en       = cic_en_q;
    assign o_cic_rst      = cic_rst_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_overrun      = overrun_q;
    assign stream.o_data  = data_q;
    assign stream.o_valid = valid_q;
endmodule

// File: tb/tb_cic_ctrl.sv
// Self-checking bench for cic_ctrl: cycle-by-cycle vector table with hand-made strobes,
// plus sequences driven by a small CIC (ORDER=5, D=4, I_WIDTH=8) model.
module tb_cic_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  num = 8'd0;
    logic        man_clk = 1'b0;
    logic [18:0] man_data = 19'd0;
    logic        use_model = 1'b0;
    logic        cic_clk;
    logic [18:0] cic_data;
    logic        cic_en, cic_rst, busy, done, overrun;

    int tests = 0;
    int fails = 0;

    cic_ctrl_if #(.O_WIDTH(19)) bus ();
    assign bus.i_ready = ready;

    cic_ctrl #(.O_WIDTH(19), .SETTLE_SAMPLES(5), .FLUSH_CYCLES(2), .CNT_BITS(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_num_samples(num), .i_cic_data(cic_data), .i_cic_clk(cic_clk),
        .o_cic_en(cic_en), .o_cic_rst(cic_rst), .o_busy(busy), .o_done(done),
        .o_overrun(overrun), .stream(bus)
    );

    always #5 clk = ~clk;

    // Reference CIC: 5 integrators at clk rate, decimate by 4, 5 combs (M=1), step input of 1
    logic [18:0] integ [5];
    logic [18:0] int_nx [5];
    logic [18:0] cdly [5];
    logic [18:0] cmb [6];
    logic [1:0]  dcnt;
    logic        mdl_clk;
    logic [18:0] mdl_data;

    always_comb begin
        int_nx[0] = integ[0] + 19'd1;
        for (int i = 1; i < 5; i++) int_nx[i] = integ[i] + int_nx[i-1];
        cmb[0] = int_nx[4];
        for (int i = 0; i < 5; i++) cmb[i+1] = cmb[i] - cdly[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || cic_rst) begin
            for (int i = 0; i < 5; i++) begin
                integ[i] <= '0;
                cdly[i]  <= '0;
            end
            dcnt     <= '0;
            mdl_clk  <= 1'b0;
            mdl_data <= '0;
        end else if (cic_en) begin
            for (int i = 0; i < 5; i++) integ[i] <= int_nx[i];
            dcnt <= dcnt + 2'd1;
            if (dcnt == 2'd3) begin
                for (int i = 0; i < 5; i++) cdly[i] <= cmb[i];
                mdl_data <= cmb[5];
                mdl_clk  <= 1'b1;
            end else if (dcnt == 2'd1) begin
                mdl_clk <= 1'b0;
            end
        end
    end

    assign cic_clk  = use_model ? mdl_clk  : man_clk;
    assign cic_data = use_model ? mdl_data : man_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // flags = {busy, cic_en, cic_rst, valid, done, overrun}
    typedef struct {
        logic        start, stop, ready, cclk;
        logic [18:0] cdata;
        logic [7:0]  num;
        logic [5:0]  flags;
        logic [18:0] data;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic st, input logic r, input logic c,
                                input logic [18:0] d, input logic [7:0] n,
                                input logic [5:0] f, input logic [18:0] ed);
        vec_t v;
        v.start = s; v.stop = st; v.ready = r; v.cclk = c;
        v.cdata = d; v.num = n; v.flags = f; v.data = ed;
        vecs.push_back(v);
    endfunction

    // Five discarded strobes; outputs must not move
    function automatic void add_settle(input logic [7:0] n, input logic [18:0] ed);
        for (int i = 0; i < 5; i++) begin
            add(0, 0, 0, 1, 19'h0AA + 19'(i), n, 6'b110000, ed);
            add(0, 0, 0, 0, 19'h0, n, 6'b110000, ed);
        end
    endfunction

    function automatic logic [5:0] flags_now();
        return {busy, cic_en, cic_rst, bus.o_valid, done, overrun};
    endfunction

    task automatic man_strobe(input logic [18:0] d);
        man_clk = 1'b1; man_data = d;
        @(posedge clk); #1;
        man_clk = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfers, strobes, disc;
        logic prev_clk, seen_valid, got_done;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("reset flags", 32'(flags_now()), 32'd0);
        chk("reset data", 32'(bus.o_data), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Backpressure with overrun, then simultaneous capture/handshake into DRAIN
        add(1, 0, 0, 0, 0, 3, 6'b101000, 0);
        add(0, 0, 0, 0, 0, 3, 6'b101000, 0);
        add(0, 0, 0, 0, 0, 3, 6'b110000, 0);
        add_settle(3, 0);
        add(0, 0, 0, 1, 19'h111, 3, 6'b110100, 19'h111);
        add(0, 0, 0, 0, 0,       3, 6'b110100, 19'h111);
        add(0, 0, 0, 1, 19'h222, 3, 6'b110101, 19'h111);
        add(0, 0, 0, 0, 0,       3, 6'b110101, 19'h111);
        add(0, 0, 1, 1, 19'h333, 3, 6'b100101, 19'h333);
        add(0, 0, 1, 0, 0,       3, 6'b000011, 19'h333);
        add(0, 0, 0, 0, 0,       3, 6'b000001, 19'h333);
        // Restart clears overrun; strobe coinciding with handshake is not an overrun
        add(1, 0, 0, 0, 0, 2, 6'b101000, 19'h333);
        add(0, 0, 0, 0, 0, 2, 6'b101000, 19'h333);
        add(0, 0, 0, 0, 0, 2, 6'b110000, 19'h333);
        add_settle(2, 19'h333);
        add(0, 0, 0, 1, 19'h0F0, 2, 6'b110100, 19'h0F0);
        add(0, 0, 0, 0, 0,       2, 6'b110100, 19'h0F0);
        add(0, 0, 1, 1, 19'h0F1, 2, 6'b100100, 19'h0F1);
        add(0, 0, 0, 0, 0,       2, 6'b100100, 19'h0F1);
        add(0, 0, 1, 0, 0,       2, 6'b000010, 19'h0F1);
        add(0, 0, 0, 0, 0,       2, 6'b000000, 19'h0F1);
        // Start pulse in SETTLE is ignored: N stays 1
        add(1, 0, 0, 0, 0, 1, 6'b101000, 19'h0F1);
        add(0, 0, 0, 0, 0, 1, 6'b101000, 19'h0F1);
        add(0, 0, 0, 0, 0, 1, 6'b110000, 19'h0F1);
        add(1, 0, 0, 0, 0, 5, 6'b110000, 19'h0F1);
        add_settle(5, 19'h0F1);
        add(0, 0, 0, 1, 19'h055, 5, 6'b100100, 19'h055);
        add(0, 0, 1, 0, 0,       5, 6'b000010, 19'h055);
        add(0, 0, 0, 0, 0,       5, 6'b000000, 19'h055);
        // Start and stop together in RUN: stop wins
        add(1, 0, 0, 0, 0, 0, 6'b101000, 19'h055);
        add(0, 0, 0, 0, 0, 0, 6'b101000, 19'h055);
        add(0, 0, 0, 0, 0, 0, 6'b110000, 19'h055);
        add_settle(0, 19'h055);
        add(0, 0, 0, 1, 19'h066, 0, 6'b110100, 19'h066);
        add(0, 0, 0, 0, 0,       0, 6'b110100, 19'h066);
        add(1, 1, 0, 0, 0,       0, 6'b000000, 19'h066);
        add(0, 0, 0, 0, 0,       0, 6'b000000, 19'h066);

        foreach (vecs[i]) begin
            start = vecs[i].start; stop = vecs[i].stop; ready = vecs[i].ready;
            man_clk = vecs[i].cclk; man_data = vecs[i].cdata; num = vecs[i].num;
            @(posedge clk); #1;
            chk($sformatf("vec%0d flags", i), 32'(flags_now()), 32'(vecs[i].flags));
            chk($sformatf("vec%0d data", i), 32'(bus.o_data), 32'(vecs[i].data));
        end

        // Asynchronous reset mid-RUN with a pending sample
        start = 1'b1; num = 8'd0; ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) man_strobe(19'h0BB);
        man_strobe(19'h1234);
        chk("pre-reset valid/data", 32'({bus.o_valid, bus.o_data}), 32'({1'b1, 19'h1234}));
        #2 rst_n = 1'b0;
        #1;
        chk("async reset flags", 32'(flags_now()), 32'd0);
        chk("async reset data", 32'(bus.o_data), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle after reset", 32'(flags_now()), 32'd0);

        // Step response through the CIC model, N=4
        use_model = 1'b1; ready = 1'b1; num = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        xfers = 0; strobes = 0; disc = -1;
        seen_valid = 1'b0; got_done = 1'b0; prev_clk = cic_clk;
        for (int c = 0; c < 400 && !got_done; c++) begin
            @(posedge clk); #1;
            if (cic_clk && !prev_clk && !seen_valid) strobes++;
            prev_clk = cic_clk;
            if (bus.o_valid && !seen_valid) begin
                seen_valid = 1'b1;
                disc = strobes - 1;
            end
            if (bus.o_valid && ready) begin
                xfers++;
                chk($sformatf("step data %0d", xfers), 32'(bus.o_data), 32'h400);
            end
            if (done) begin
                got_done = 1'b1;
                chk("step overrun", 32'(overrun), 32'd0);
                chk("step busy at done", 32'(busy), 32'd0);
            end
        end
        chk("step done seen", 32'(got_done), 32'd1);
        chk("step transfers", 32'(xfers), 32'd4);
        chk("step discarded", 32'(disc), 32'd5);
        @(posedge clk); #1;
        chk("step done one cycle", 32'(done), 32'd0);

        // Continuous mode past counter wrap, then stop and restart
        num = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        strobes = 0; prev_clk = cic_clk;
        for (int c = 0; c < 3000 && strobes < 310; c++) begin
            @(posedge clk); #1;
            if (cic_clk && !prev_clk) strobes++;
            prev_clk = cic_clk;
        end
        chk("cont strobes", 32'(strobes), 32'd310);
        chk("cont busy/ovr", 32'({busy, cic_en, overrun}), 32'b110);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        chk("stop flags", 32'(flags_now()), 32'd0);
        @(posedge clk); #1;
        chk("stop no done", 32'(flags_now()), 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("reflush c1", 32'({busy, cic_en, cic_rst}), 32'b101);
        @(posedge clk); #1;
        chk("reflush c2", 32'({busy, cic_en, cic_rst}), 32'b101);
        @(posedge clk); #1;
        chk("reflush end", 32'({busy, cic_en, cic_rst}), 32'b110);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        chk("final idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cic_ctrl.md
# cic_ctrl

Acquisition controller that sequences one `cic` decimator for the iCESDM readout. It flushes the filter, discards the start-up transient, and captures a programmed number of decimated samples. Each sample is presented downstream through a valid/ready handshake, and dropped samples are flagged. It sits between the CIC output (`o_data`/`o_clk`) and the sample consumer (UART/SPI packer), and drives the CIC's `i_en`/`i_rst`.

## Interface
- `O_WIDTH`, 19: width of CIC output word and `o_data`.
- `SETTLE_SAMPLES`, 5: decimated samples discarded after flush (set equal to CIC ORDER).
- `FLUSH_CYCLES`, 2: `i_clk` cycles `o_cic_rst` is held high.
- `CNT_BITS`, 8: width of sample-count request and counters.

- `i_clk`  in  1  system clock; also clocks the CIC.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  start acquisition; sampled in IDLE only.
- `i_stop`  in  1  abort acquisition; sampled in every state except IDLE.
- `i_num_samples`  in  CNT_BITS  samples to capture, latched at start; 0 = continuous until `i_stop`.
- `i_cic_data`  in  O_WIDTH  CIC `o_data`.
- `i_cic_clk`  in  1  CIC `o_clk` (decimated clock, synchronous to `i_clk`).
- `o_cic_en`  out  1  CIC enable.
- `o_cic_rst`  out  1  CIC reset, active-high.
- `o_data`  out  O_WIDTH  captured sample.
- `o_valid`  out  1  `o_data` holds an unconsumed sample.
- `i_ready`  in  1  consumer accepts; transfer occurs when `o_valid && i_ready` at a rising `i_clk` edge.
- `o_busy`  out  1  state is not IDLE.
- `o_done`  out  1  one-cycle pulse on normal completion.
- `o_overrun`  out  1  sticky: a sample was dropped since last start.

## Operation
- Strobe: `stb = i_cic_clk & ~cic_clk_q`, where `cic_clk_q` is `i_cic_clk` registered. `i_cic_data` is sampled in the `stb` cycle.
- States: IDLE, FLUSH, SETTLE, RUN, DRAIN. All outputs are registered.
- IDLE:
  - `o_cic_en`=0, `o_cic_rst`=0.
  - `i_start`=1 -> FLUSH. Latches `i_num_samples`, clears `o_overrun`, `o_valid` and both counters.
- FLUSH:
  - `o_cic_rst`=1, `o_cic_en`=0 for exactly FLUSH_CYCLES cycles.
  - Then -> SETTLE.
- SETTLE:
  - `o_cic_en`=1.
  - Each `stb` increments the settle counter; samples are discarded.
  - On the SETTLE_SAMPLES-th `stb` -> RUN. That sample is not captured.
  - SETTLE_SAMPLES=0 goes straight to RUN.
- RUN:
  - `o_cic_en`=1. Each `stb` increments the sample counter.
  - If `!o_valid || i_ready`: `o_data`<=`i_cic_data`, `o_valid`<=1. This includes a handshake and strobe in the same cycle, which is no overrun.
  - Else the sample is dropped, `o_overrun`<=1, `o_data` is unchanged, and the sample still counts.
  - When the count reaches the latched non-zero N -> DRAIN, `o_cic_en`<=0.
- DRAIN:
  - Wait for `!o_valid`, or for a transfer in the current cycle.
  - Then -> IDLE with `o_done`=1 for one cycle.
- `i_stop`=1 in FLUSH/SETTLE/RUN/DRAIN -> IDLE next cycle:
  - `o_valid`<=0, `o_cic_en`<=0, no `o_done`.
  - `o_overrun` is retained.
- `i_start` while busy is ignored. If `i_start` and `i_stop` are both asserted in a busy state, stop wins.
- Without a handshake, `o_valid` clears only on transfer, stop, or reset.
- Counter wrap: in continuous mode the counter wraps freely at 2^CNT_BITS. It has no effect on state.

## Timing
- Reset (`i_rst_n`=0, async): state=IDLE, `o_cic_en`=0, `o_cic_rst`=0, `o_data`=0, `o_valid`=0, `o_busy`=0, `o_done`=0, `o_overrun`=0, `cic_clk_q`=0, counters=0.
- Reset mid-acquisition aborts immediately with the same values. The first cycle after release is IDLE.
- `i_start` high at edge k: `o_busy`=1 and `o_cic_rst`=1 from edge k+1; `o_cic_en`=1 from edge k+1+FLUSH_CYCLES.
- Capture latency: `stb` in cycle j -> `o_data`/`o_valid` updated at the edge ending cycle j (visible cycle j+1).
- Sustained throughput: one sample per CIC decimation period. The consumer must accept within D `i_clk` cycles to avoid overrun.
- `o_done` is asserted the cycle after the final transfer. `o_busy` falls together with `o_done`.

## Test plan
- Step, N=4: CIC (I_WIDTH=8, ORDER=5, D=4) input held at 1, `i_ready`=1, start. Required:
  - exactly 4 transfers, all `o_data`=0x00400;
  - 5 strobes discarded before the first capture;
  - `o_done` pulse, `o_overrun`=0.
- Reset values: assert `i_rst_n`=0 mid-RUN with `o_valid`=1. Required: all outputs go to their reset values asynchronously, before the next clock edge; `o_cic_en`=0.
- Backpressure: N=3, `i_ready`=0 through 2 strobes in RUN. Required:
  - `o_overrun`=1, `o_data` holds the first sample;
  - after `i_ready`=1, exactly 1 transfer then DRAIN -> `o_done`.
- Simultaneous strobe and handshake: align `i_ready` with `stb` while `o_valid`=1. Required: new sample loaded, `o_valid` stays 1, `o_overrun`=0.
- Stop, continuous mode (N=0): run more than 300 strobes (counter wrap), then `i_stop`. Required:
  - IDLE next cycle, `o_valid`=0, `o_cic_en`=0, no `o_done`;
  - a subsequent `i_start` re-flushes (`o_cic_rst` high for 2 cycles).
- Start while busy and start/stop collision: `i_start` pulse in SETTLE is ignored (latched N unchanged). `i_start`+`i_stop` together in RUN -> IDLE.
